mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Sequences the CPU's single memory port between two requesters: the instruction-fetch path (I) and the load/store data path (D). It owns read_m, write_m, address and the write-data drive. Each access runs as a fixed-latency transaction, and completion is reported with a one-cycle ack plus registered read data. It sits between the multi-cycle control/datapath and the external memory model, so the datapath never drives the memory strobes directly.

Parameters:
WORD_SIZE, 16, width of address and data words
MEM_LATENCY, 2, cycles read_m/write_m are held per access (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  synchronous reset, active-high (1 = reset); sampled on rising clk edge
i_req  input  1  fetch request; held until i_ack
i_addr  input  WORD_SIZE  fetch address
i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  output  WORD_SIZE  registered fetched word
d_req  input  1  data request; held until d_ack
d_we  input  1  1 = store, 0 = load
d_addr  input  WORD_SIZE  data address
d_wdata  input  WORD_SIZE  store data
d_ack  output  1  one-cycle pulse: data access complete
d_rdata  output  WORD_SIZE  registered load data
read_m  output  1  memory read strobe
write_m  output  1  memory write strobe
address  output  WORD_SIZE  memory address
mem_wdata  output  WORD_SIZE  value driven onto memory data bus while write_m = 1
mem_rdata  input  WORD_SIZE  memory data bus, read side
busy  output  1  1 in any state other than IDLE
access_count  output  WORD_SIZE  number of completed accesses

Behaviour:
- Clock and reset: one clock (clk). Synchronous, active-high reset on reset_n.
- Reset values: state = IDLE. Outputs read_m, write_m, i_ack, d_ack and busy = 0. Outputs address, mem_wdata, i_rdata, d_rdata and access_count = 0. The latency counter = 0.
- Reset mid-access: the transaction is dropped. The strobes are 0 in the cycle after the reset edge. No ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If d_req = 1: grant D. Register address <= d_addr, mem_wdata <= d_wdata, owner <= D, is_write <= d_we. Go to ACCESS.
  - Else if i_req = 1: grant I. Register address <= i_addr, is_write <= 0. Go to ACCESS.
  - Else stay in IDLE.
- Priority: D always beats I when both requests are sampled high in the same IDLE cycle. The stalled I request is served in the next IDLE cycle.
- ACCESS:
  - read_m = ~is_write and write_m = is_write, both registered outputs.
  - The strobe is high for exactly MEM_LATENCY consecutive cycles. address and mem_wdata are stable throughout.
  - On the final ACCESS cycle, for a read: capture mem_rdata into i_rdata or d_rdata according to owner. Then go to RESP.
- RESP:
  - Strobes = 0. Owner's ack = 1 for exactly this cycle.
  - access_count increments by 1, wrapping 0xFFFF -> 0x0000.
  - Requests are ignored in this cycle. Always return to IDLE next.
- Handshake rule: the requester deasserts req on the clock edge that ends the ack cycle, so IDLE samples req = 0.
  - A req still high in IDLE is treated as a new request. Back-to-back same-port accesses are therefore legal.
- Latency: req sampled in IDLE at cycle t -> strobe high in cycles t+1..t+MEM_LATENCY -> ack in cycle t+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+2 cycles.
- Stores: d_rdata is unchanged, and d_ack is still pulsed.
- Held data: i_rdata and d_rdata hold their values until that port's next read completes.
- Protocol violations:
  - req dropped during ACCESS: the access completes and the ack pulses anyway.
  - address or wdata changed during ACCESS: ignored, because the values were registered at grant.
- Invariants: never read_m & write_m. Never i_ack & d_ack. Acks occur only in RESP.

Test Plan:
- Reset: hold reset_n = 1 for 2 cycles with i_req = 1 -> all outputs 0, state IDLE. Release -> fetch grant on the next edge.
- Single fetch (MEM_LATENCY = 2): i_req with i_addr = 0x0010, memory returns 0x6A01 -> read_m high for 2 cycles with address = 0x0010. i_ack in the 4th cycle after the req sample, i_rdata = 0x6A01, access_count = 1.
- Store: d_req, d_we = 1, d_addr = 0x0080, d_wdata = 0xBEEF -> write_m high for 2 cycles, mem_wdata = 0xBEEF, read_m = 0, d_ack pulses, d_rdata unchanged.
- Contention: i_req and d_req rise together (load at 0x0040 returning 0x1234; fetch at 0x0011) -> D served first, d_rdata = 0x1234. I granted in the IDLE cycle after d_ack, i_ack 4 cycles later, 8 cycles total.
- Reset mid-access: assert reset_n during the first ACCESS cycle -> strobes 0 next cycle, no ack, access_count unchanged.
- Wrap and latency: preload access_count = 0xFFFF via 65535 accesses (or force); run with MEM_LATENCY = 1 and MEM_LATENCY = 5 -> count wraps to 0x0000, strobe widths exactly 1 and 5 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single memory-port arbiter: grants the data path over instruction fetch and runs
// each access as a fixed-latency strobe window followed by a one-cycle ack.
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 read_m,
    output logic                 write_m,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] access_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    state_t               state_q, state_d;
    owner_t               owner_q, owner_d;
    logic                 is_write_q, is_write_d;
    logic [3:0]           lat_cnt_q, lat_cnt_d;
    logic                 read_m_q, read_m_d;
    logic                 write_m_q, write_m_d;
    logic [WORD_SIZE-1:0] address_q, address_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic [WORD_SIZE-1:0] access_count_q, access_count_d;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        is_write_d     = is_write_q;
        lat_cnt_d      = lat_cnt_q;
        read_m_d       = read_m_q;
        write_m_d      = write_m_q;
        address_d      = address_q;
        mem_wdata_d    = mem_wdata_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        i_ack_d        = 1'b0;
        d_ack_d        = 1'b0;
        access_count_d = access_count_q;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    address_d   = d_addr;
                    mem_wdata_d = d_wdata;
                    owner_d     = OWN_D;
                    is_write_d  = d_we;
                    read_m_d    = ~d_we;
                    write_m_d   = d_we;
                    lat_cnt_d   = '0;
                    state_d     = ACCESS;
                end else if (i_req) begin
                    address_d  = i_addr;
                    owner_d    = OWN_I;
                    is_write_d = 1'b0;
                    read_m_d   = 1'b1;
                    write_m_d  = 1'b0;
                    lat_cnt_d  = '0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // Strobes are registered, so they drop on the same edge that enters RESP.
                if (lat_cnt_q == LAT_LAST) begin
                    read_m_d  = 1'b0;
                    write_m_d = 1'b0;
                    if (!is_write_q) begin
                        if (owner_q == OWN_D) d_rdata_d = mem_rdata;
                        else                  i_rdata_d = mem_rdata;
                    end
                    i_ack_d        = (owner_q == OWN_I);
                    d_ack_d        = (owner_q == OWN_D);
                    access_count_d = access_count_q + 1'b1;
                    state_d        = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q        <= IDLE;
            owner_q        <= OWN_I;
            is_write_q     <= 1'b0;
            lat_cnt_q      <= '0;
            read_m_q       <= 1'b0;
            write_m_q      <= 1'b0;
            address_q      <= '0;
            mem_wdata_q    <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            i_ack_q        <= 1'b0;
            d_ack_q        <= 1'b0;
            access_count_q <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            is_write_q     <= is_write_d;
            lat_cnt_q      <= lat_cnt_d;
            read_m_q       <= read_m_d;
            write_m_q      <= write_m_d;
            address_q      <= address_d;
            mem_wdata_q    <= mem_wdata_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            i_ack_q        <= i_ack_d;
            d_ack_q        <= d_ack_d;
            access_count_q <= access_count_d;
        end
    end

    assign read_m       = read_m_q;
    assign write_m      = write_m_q;
    assign address      = address_q;
    assign mem_wdata    = mem_wdata_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign i_ack        = i_ack_q;
    assign d_ack        = d_ack_q;
    assign access_count = access_count_q;
    assign busy         = (state_q != IDLE);

endmodule
